// File: rtl/uart_receiver.sv
// Purpose     : UART receiver with 16x oversampling, 8N1 framing, framing-error flag.
// Latency     : start edge (after sync) to rx_done = 8 + 16*DATA_BITS + SB_TICKS s_ticks, plus 1 clk.
// Backpressure: none; each byte is offered once on a one-cycle rx_done strobe and held on rx_out.
module uart_receiver #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int SB_TICKS   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_in,
   input  logic                 s_tick,
   output logic [DATA_BITS-1:0] rx_out,
   output logic                 rx_done,
   output logic                 busy,
   output logic                 err
);

   // Tick counter covers the longer of a data bit and the stop-bit wait.
   localparam int TICK_MAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
   localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
   localparam int BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] START_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] DATA_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] STOP_LAST  = TW'(SB_TICKS - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // Synchroniser and edge-detect flops.
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic rx_s_d_q, rx_s_d_d;

   // Frame engine state.
   state_t               state_q, state_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;

   // Registered outputs.
   logic [DATA_BITS-1:0] rx_out_q, rx_out_d;
   logic                 rx_done_q, rx_done_d;
   logic                 busy_q, busy_d;
   logic                 err_q, err_d;

   logic rx_s;
   logic start_edge;

   assign rx_s       = sync2_q;
   assign start_edge = rx_s_d_q & ~rx_s;

   // Two-flop synchroniser on the async line, then one flop of history for edge detection.
   always_comb begin
      sync1_d  = rx_in;
      sync2_d  = sync1_q;
      rx_s_d_d = sync2_q;
   end

   // Frame sequencing: half-bit start qualification, mid-bit data sampling, stop-bit check.
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      rx_out_d  = rx_out_q;
      err_d     = err_q;
      rx_done_d = 1'b0;

      case (state_q)
         IDLE: begin
            // Only a high-to-low transition starts a frame, so a held-low line never retriggers.
            if (start_edge) begin
               state_d = START;
               tick_d  = '0;
            end
         end

         START: begin
            if (s_tick) begin
               if (tick_q == START_LAST) begin
                  if (!rx_s) begin
                     state_d = DATA;
                     tick_d  = '0;
                     bit_d   = '0;
                  end else begin
                     // Line is back high at mid start bit: treat as a glitch.
                     state_d = IDLE;
                     tick_d  = '0;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end

         DATA: begin
            if (s_tick) begin
               if (tick_q == DATA_LAST) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  tick_d  = '0;
                  if (bit_q == BIT_LAST) begin
                     state_d = STOP;
                  end else begin
                     bit_d = bit_q + BW'(1);
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end

         STOP: begin
            if (s_tick) begin
               if (tick_q == STOP_LAST) begin
                  rx_out_d  = shift_q;
                  err_d     = ~rx_s;
                  rx_done_d = 1'b1;
                  state_d   = IDLE;
                  tick_d    = '0;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
            tick_d  = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset aborts any frame in flight and parks the line detector high.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_s_d_q  <= 1'b1;
         state_q   <= IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         rx_out_q  <= '0;
         rx_done_q <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         rx_s_d_q  <= rx_s_d_d;
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         rx_out_q  <= rx_out_d;
         rx_done_q <= rx_done_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign rx_out  = rx_out_q;
   assign rx_done = rx_done_q;
   assign busy    = busy_q;
   assign err     = err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: a behavioural serial sender drives rx_in, received bytes are
// collected from rx_done pulses and compared with what the sender put on the line.
// The expected error flag of a frame is simply the inverse of the stop-bit level sent.
module tb_uart_receiver;

   localparam int DW     = 8;
   localparam int TDIV   = 4;            // clk cycles per s_tick
   localparam int BITCLK = TDIV * 16;    // clk cycles per nominal bit

   logic          clk = 1'b0;
   logic          reset;
   logic          rx_in;
   logic          s_tick;
   logic [DW-1:0] rx_out;
   logic          rx_done;
   logic          busy;
   logic          err;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          e;
   } rec_t;

   rec_t got[$];

   uart_receiver #(.DATA_BITS(DW), .OVERSAMPLE(16), .SB_TICKS(16)) dut (
      .clk     (clk),
      .reset   (reset),
      .rx_in   (rx_in),
      .s_tick  (s_tick),
      .rx_out  (rx_out),
      .rx_done (rx_done),
      .busy    (busy),
      .err     (err)
   );

   always #5 clk = ~clk;

   // Free-running 16x tick source.
   initial begin : tick_gen
      int cnt;
      cnt    = 0;
      s_tick = 1'b0;
      forever begin
         @(negedge clk);
         cnt    = (cnt + 1) % TDIV;
         s_tick = (cnt == 0);
      end
   end

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Collect every received byte; a strobe must never last more than one cycle.
   initial begin : monitor
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rx_done === 1'b1) begin
            cmp("done_width", {31'd0, prev}, 32'd0);
            got.push_back({rx_out, err});
         end
         prev = rx_done;
      end
   end

   task automatic drive_bit(input logic b, input int clks);
      rx_in = b;
      repeat (clks) @(negedge clk);
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic stop, input int bc);
      drive_bit(1'b0, bc);
      for (int i = 0; i < DW; i++) drive_bit(d[i], bc);
      drive_bit(stop, bc);
   endtask

   task automatic check_rx(input string tag, input logic [DW-1:0] d, input logic e);
      int   w;
      rec_t r;
      w = 0;
      while (got.size() == 0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      cmp({tag, "_arrived"}, (got.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (got.size() != 0) begin
         r = got.pop_front();
         cmp({tag, "_data"}, {24'd0, r.d}, {24'd0, d});
         cmp({tag, "_err"}, {31'd0, r.e}, {31'd0, e});
      end
   endtask

   task automatic check_none(input string tag, input int clks);
      repeat (clks) @(negedge clk);
      cmp(tag, got.size(), 32'd0);
      got.delete();
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin : main
      logic [DW-1:0] t1 [8];
      logic [DW-1:0] b;
      logic [DW-1:0] v81;
      int            bc;
      t1 = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};

      // Reset state
      rx_in = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      cmp("rst_rx_out",  {24'd0, rx_out}, 32'd0);
      cmp("rst_rx_done", {31'd0, rx_done}, 32'd0);
      cmp("rst_busy",    {31'd0, busy}, 32'd0);
      cmp("rst_err",     {31'd0, err}, 32'd0);
      reset = 1'b0;
      drive_bit(1'b1, 2 * BITCLK);

      // Fixed byte loopback
      foreach (t1[i]) begin
         send_frame(t1[i], 1'b1, BITCLK);
         check_rx($sformatf("loop%0d", i), t1[i], 1'b0);
      end
      drive_bit(1'b1, BITCLK);

      // Glitch: low for 4 ticks, then high
      rx_in = 1'b0;
      repeat (6) @(negedge clk);
      cmp("glitch_busy_hi", {31'd0, busy}, 32'd1);
      repeat (4 * TDIV - 6) @(negedge clk);
      rx_in = 1'b1;
      repeat (8 * TDIV) @(negedge clk);
      cmp("glitch_busy_lo", {31'd0, busy}, 32'd0);
      check_none("glitch_nodone", BITCLK);
      send_frame(8'h3C, 1'b1, BITCLK);
      check_rx("after_glitch", 8'h3C, 1'b0);
      drive_bit(1'b1, BITCLK);

      // Framing error followed by a long break
      send_frame(8'hC3, 1'b0, BITCLK);
      check_rx("frame_err", 8'hC3, 1'b1);
      drive_bit(1'b0, 40 * BITCLK);
      cmp("break_busy", {31'd0, busy}, 32'd0);
      check_none("break_nodone", 0);
      drive_bit(1'b1, 2 * BITCLK);
      b = 8'($urandom);
      send_frame(b, 1'b1, BITCLK);
      check_rx("after_break", b, 1'b0);
      drive_bit(1'b1, BITCLK);

      // Reset in the middle of bit 4 of 0x81
      v81 = 8'h81;
      drive_bit(1'b0, BITCLK);
      for (int i = 0; i < 4; i++) drive_bit(v81[i], BITCLK);
      drive_bit(v81[4], BITCLK / 2);
      reset = 1'b1;
      rx_in = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cmp("midrst_busy",   {31'd0, busy}, 32'd0);
      cmp("midrst_rx_out", {24'd0, rx_out}, 32'd0);
      cmp("midrst_err",    {31'd0, err}, 32'd0);
      check_none("midrst_nodone", 12 * BITCLK);
      send_frame(8'h7E, 1'b1, BITCLK);
      check_rx("after_rst", 8'h7E, 1'b0);
      drive_bit(1'b1, BITCLK);

      // Back-to-back with no idle gap
      send_frame(8'h01, 1'b1, BITCLK);
      send_frame(8'h80, 1'b1, BITCLK);
      check_rx("b2b_0", 8'h01, 1'b0);
      check_rx("b2b_1", 8'h80, 1'b0);
      drive_bit(1'b1, BITCLK);

      // Sender bit rate skewed about +3% / -3% against the tick source
      send_frame(8'h55, 1'b1, 66);
      check_rx("skew_slow", 8'h55, 1'b0);
      drive_bit(1'b1, BITCLK);
      send_frame(8'hAA, 1'b1, 62);
      check_rx("skew_fast", 8'hAA, 1'b0);

      // Random bytes, random small skew, random idle gaps
      for (int i = 0; i < 6; i++) begin
         drive_bit(1'b1, $urandom_range(100, 1));
         b  = 8'($urandom);
         bc = $urandom_range(66, 62);
         send_frame(b, 1'b1, bc);
         check_rx($sformatf("rand%0d", i), b, 1'b0);
      end

      check_none("no_extra", 2 * BITCLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
